// File: rtl/cyber_pkg.sv
// Shared types and constants for the cyber_player computer opponent.
// The state enum, the LFSR seed and the feedback tap positions all live here.
package cyber_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      FIRE,
      HOLD
   } cyber_state_e;

   localparam logic [9:0]  LFSR_SEED   = 10'h001;
   localparam int unsigned LFSR_TAP_HI = 9;
   localparam int unsigned LFSR_TAP_LO = 6;

endpackage

// File: rtl/cyber_player_if.sv
// Game-side bundle for cyber_player.
// The game (master) drives enable and speed; the player (slave) drives press and lfsr_q.
interface cyber_player_if #(
   parameter int unsigned LFSR_W  = 10,
   parameter int unsigned SPEED_W = 9
);

   logic               enable;
   logic [SPEED_W-1:0] speed;
   logic               press;
   logic [LFSR_W-1:0]  lfsr_q;

   modport master (output enable, output speed, input press, input lfsr_q);
   modport slave  (input enable, input speed, output press, output lfsr_q);

endinterface

// File: rtl/cyber_lfsr.sv
// Fibonacci XOR LFSR that advances only when step is high.
// The state reloads the seed on reset; an all-zero state is never reached.
module cyber_lfsr
   import cyber_pkg::*;
#(
   parameter int unsigned LFSR_W = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              step,
   output logic [LFSR_W-1:0] q
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= LFSR_W'(LFSR_SEED);
      end else if (step) begin
         q <= {q[LFSR_W-2:0], q[LFSR_TAP_HI] ^ q[LFSR_TAP_LO]};
      end
   end

endmodule

// File: rtl/cyber_player.sv
// Computer opponent for tug-of-war: emits one-cycle press pulses paced by a prescaler and an LFSR draw.
// Define CYBER_PLAYER_HOLDOFF_EN to suppress firing for HOLDOFF_TICKS ticks after every press.
module cyber_player
   import cyber_pkg::*;
#(
   parameter int unsigned LFSR_W        = 10,
   parameter int unsigned SPEED_W       = 9,
   parameter int unsigned TICK_DIV      = 4,
   parameter int unsigned HOLDOFF_TICKS = 2
) (
   input  logic           clk,
   input  logic           reset,
   cyber_player_if.slave  bus
);

   localparam int unsigned CNT_W = $clog2(TICK_DIV);

`ifdef CYBER_PLAYER_HOLDOFF_EN
   localparam bit          HOLD_EN = (HOLDOFF_TICKS > 0);
   localparam int unsigned HOLD_W  = (HOLDOFF_TICKS > 1) ? $clog2(HOLDOFF_TICKS + 1) : 1;
`else
   // Hold-off compiled out; the parameter stays so existing overrides still elaborate.
   localparam bit          HOLD_EN = (HOLDOFF_TICKS > 0) && 1'b0;
`endif

   logic [SPEED_W-1:0] speed_m;
   logic [SPEED_W-1:0] speed_s;
   logic [LFSR_W-1:0]  threshold;
   logic [LFSR_W-1:0]  lfsr_q;
   logic [CNT_W-1:0]   cnt;
   logic               tick;
   logic               hit;
   logic               press_q;
   cyber_state_e       state_q;
   cyber_state_e       state_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         speed_m <= '0;
         speed_s <= '0;
      end else begin
         speed_m <= bus.speed;
         speed_s <= speed_m;
      end
   end

   assign threshold = LFSR_W'(speed_s) << (LFSR_W - SPEED_W);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (!bus.enable || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign tick = bus.enable && (cnt == CNT_W'(TICK_DIV - 1));
   assign hit  = tick && (lfsr_q < threshold);

   cyber_lfsr #(
      .LFSR_W (LFSR_W)
   ) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .step  (tick),
      .q     (lfsr_q)
   );

`ifdef CYBER_PLAYER_HOLDOFF_EN
   logic [HOLD_W-1:0] hold_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hold_cnt <= '0;
      end else if (state_q == FIRE) begin
         hold_cnt <= HOLD_W'(HOLDOFF_TICKS);
      end else if (state_q == HOLD && tick) begin
         hold_cnt <= hold_cnt - HOLD_W'(1);
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  state_d = ARMED;
         ARMED: if (hit) state_d = FIRE;
         FIRE:  state_d = HOLD_EN ? HOLD : ARMED;
         HOLD: begin
`ifdef CYBER_PLAYER_HOLDOFF_EN
            if (tick && hold_cnt == HOLD_W'(1)) state_d = ARMED;
`else
            state_d = ARMED;
`endif
         end
         default: state_d = IDLE;
      endcase
      if (!bus.enable) state_d = IDLE;
   end

   // press is registered from the next state so it is high exactly while state_q is FIRE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         press_q <= 1'b0;
      end else begin
         state_q <= state_d;
         press_q <= (state_d == FIRE);
      end
   end

   assign bus.press  = press_q;
   assign bus.lfsr_q = lfsr_q;

endmodule

// File: tb/tb_cyber_player.sv
// Self-checking bench for cyber_player: cycle-level reference model of ticks, LFSR draws and hold-off.
// Follows the build's CYBER_PLAYER_HOLDOFF_EN setting for its expectations.
module tb_cyber_player;

   localparam int unsigned TD = 4;
   localparam int unsigned HO = 2;
`ifdef CYBER_PLAYER_HOLDOFF_EN
   localparam int HOLD_M = HO;
`else
   localparam int HOLD_M = 0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   cyber_player_if #(.LFSR_W(10), .SPEED_W(9)) bus ();

   cyber_player #(
      .LFSR_W        (10),
      .SPEED_W       (9),
      .TICK_DIV      (TD),
      .HOLDOFF_TICKS (HO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [9:0] m_lfsr;

   function automatic logic [9:0] lfsr_next(input logic [9:0] v);
      return {v[8:0], v[9] ^ v[6]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.enable = 1'b0;
      bus.speed  = '0;
      reset      = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      m_lfsr = 10'h001;
   endtask

   // Runs one enable window of ncyc cycles from a quiet (enable low) start and checks every cycle.
   task automatic run_game(input logic [8:0] s, input int ncyc, input bit drop_on_press,
                           output int presses);
      logic [9:0] thr;
      logic [9:0] pre;
      int         supp;
      bit         exp_p;
      thr     = {s, 1'b0};
      supp    = 0;
      presses = 0;
      bus.speed = s;
      repeat (3) step();
      bus.enable = 1'b1;
      for (int c = 1; c <= ncyc; c++) begin
         step();
         exp_p = 1'b0;
         if (c % TD == 0) begin
            pre    = m_lfsr;
            m_lfsr = lfsr_next(pre);
            if (pre < thr && supp == 0) begin
               exp_p = 1'b1;
               supp  = HOLD_M;
            end else if (supp > 0) begin
               supp--;
            end
         end
         n_cmp++;
         if (bus.press !== exp_p) begin
            n_bad++;
            $display("FAIL press spd=%h cyc=%0d: got %b want %b", s, c, bus.press, exp_p);
         end
         n_cmp++;
         if (bus.lfsr_q !== m_lfsr) begin
            n_bad++;
            $display("FAIL lfsr spd=%h cyc=%0d: got %h want %h", s, c, bus.lfsr_q, m_lfsr);
         end
         if (bus.press === 1'b1) presses++;
         if (drop_on_press && exp_p) break;
      end
      bus.enable = 1'b0;
      for (int k = 0; k < int'(TD) + 1; k++) begin
         step();
         n_cmp++;
         if (bus.press !== 1'b0 || bus.lfsr_q !== m_lfsr) begin
            n_bad++;
            $display("FAIL idle_after_drop k=%0d: got press=%b lfsr=%h want press=0 lfsr=%h",
                     k, bus.press, bus.lfsr_q, m_lfsr);
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if (bus.press !== 1'b0 || bus.lfsr_q !== 10'h001) begin
         n_bad++;
         $display("FAIL reset_state: got press=%b lfsr=%h want press=0 lfsr=001", bus.press, bus.lfsr_q);
      end
      bus.speed = 9'h1FF;
      repeat (3) step();
      bus.enable = 1'b1;
      repeat (TD) step();
      n_cmp++;
      if (bus.press !== 1'b1) begin
         n_bad++;
         $display("FAIL pre_reset_press: got %b want 1", bus.press);
      end
      #2 reset = 1'b0;
      #1;
      n_cmp++;
      if (bus.press !== 1'b0 || bus.lfsr_q !== 10'h001) begin
         n_bad++;
         $display("FAIL async_reset: got press=%b lfsr=%h want press=0 lfsr=001", bus.press, bus.lfsr_q);
      end
      bus.enable = 1'b0;
      step();
      reset = 1'b1;
      m_lfsr = 10'h001;
      for (int k = 0; k < 6; k++) begin
         step();
         n_cmp++;
         if (bus.press !== 1'b0 || bus.lfsr_q !== 10'h001) begin
            n_bad++;
            $display("FAIL post_release k=%0d: got press=%b lfsr=%h want press=0 lfsr=001",
                     k, bus.press, bus.lfsr_q);
         end
      end
   endtask

   task automatic test_low_speed();
      int p;
      do_reset();
      run_game(9'h001, 7 * TD, 1'b0, p);
      n_cmp++;
      if (p != 1) begin
         n_bad++;
         $display("FAIL low_speed_count: got %0d want 1", p);
      end
      n_cmp++;
      if (bus.lfsr_q !== 10'h081) begin
         n_bad++;
         $display("FAIL low_speed_lfsr: got %h want 081", bus.lfsr_q);
      end
   endtask

   task automatic test_zero_speed();
      int p;
      run_game(9'h000, 5000, 1'b0, p);
      n_cmp++;
      if (p != 0) begin
         n_bad++;
         $display("FAIL zero_speed_count: got %0d want 0", p);
      end
   endtask

   task automatic test_back_to_back();
      int p;
      do_reset();
      run_game(9'h1FF, 1023 * TD, 1'b0, p);
`ifdef CYBER_PLAYER_HOLDOFF_EN
      n_cmp++;
      if (p > 341 || p == 0) begin
         n_bad++;
         $display("FAIL holdoff_count: got %0d want 1..341", p);
      end
`else
      n_cmp++;
      if (p != 1021) begin
         n_bad++;
         $display("FAIL full_speed_count: got %0d want 1021", p);
      end
`endif
   endtask

   task automatic test_enable_drop();
      int p;
      run_game(9'h1FF, 400, 1'b1, p);
      n_cmp++;
      if (p != 1) begin
         n_bad++;
         $display("FAIL drop_on_fire_count: got %0d want 1", p);
      end
      run_game(9'h1FF, 3 * TD, 1'b0, p);
   endtask

   task automatic test_random();
      int p;
      for (int i = 0; i < 8; i++) begin
         run_game(9'($urandom_range(0, 511)), int'($urandom_range(20, 400)), 1'($urandom_range(0, 1)), p);
      end
   endtask

   initial begin
      bus.enable = 1'b0;
      bus.speed  = '0;
      reset      = 1'b1;
      #2;
      test_reset();
      test_low_speed();
      test_zero_speed();
      test_back_to_back();
      test_enable_drop();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
